// File: rtl/char_mover_tiled.sv
// Tile-based sprite mover: a tick divider starts a step attempt that tries the
// queued turn first, then the current direction, against a wall tilemap.
//
// state   | meaning
// IDLE    | waiting for a qualifying tick
// EVAL_Q  | test the queued direction; take it if passable
// EVAL_C  | test the current direction unless the queue was taken
// COMMIT  | load the selected target into x/y
module char_mover_tiled #(
  parameter int WIDTH    = 640,
  parameter int HEIGHT   = 480,
  parameter int TILE     = 20,
  parameter int SPEED    = 5,
  parameter int BX0      = 80,
  parameter int BX1      = 560,
  parameter int BY0      = 60,
  parameter int BY1      = 420,
  parameter int STEP_DIV = 1,
  parameter int WRAP_X   = 0,
  parameter int START_X  = 80,
  parameter int START_Y  = 60,
  localparam int COLS    = WIDTH / TILE,
  localparam int ROWS    = HEIGHT / TILE,
  localparam int XW      = $clog2(WIDTH),
  localparam int YW      = $clog2(HEIGHT)
) (
  input  logic                 clk_i,
  input  logic                 reset_i,
  input  logic                 tick_i,
  input  logic                 w_i,
  input  logic                 a_i,
  input  logic                 s_i,
  input  logic                 d_i,
  input  logic [COLS*ROWS-1:0] tilemap_i,
  output logic [XW-1:0]        x_o,
  output logic [YW-1:0]        y_o,
  output logic [1:0]           dir_o,
  output logic                 moving_o,
  output logic                 blocked_o,
  output logic                 step_done_o
);

  localparam int MW    = $clog2(COLS * ROWS);
  localparam int DW    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int XMAX  = BX1 - TILE;
  localparam int YMAX  = BY1 - TILE;
  localparam int TM1   = TILE - 1;
  localparam int DLAST = STEP_DIV - 1;

  localparam logic signed [XW:0] SPX    = SPEED[XW:0];
  localparam logic signed [XW:0] BX0_S  = BX0[XW:0];
  localparam logic signed [XW:0] XMAX_S = XMAX[XW:0];
  localparam logic signed [YW:0] SPY    = SPEED[YW:0];
  localparam logic signed [YW:0] BY0_S  = BY0[YW:0];
  localparam logic signed [YW:0] YMAX_S = YMAX[YW:0];
  localparam logic [XW-1:0] TILE_X   = TILE[XW-1:0];
  localparam logic [XW-1:0] TM1_X    = TM1[XW-1:0];
  localparam logic [YW-1:0] TILE_Y   = TILE[YW-1:0];
  localparam logic [YW-1:0] TM1_Y    = TM1[YW-1:0];
  localparam logic [XW-1:0] START_XV = START_X[XW-1:0];
  localparam logic [YW-1:0] START_YV = START_Y[YW-1:0];
  localparam logic [DW-1:0] DIV_LAST = DLAST[DW-1:0];

  typedef enum logic [1:0] {S_IDLE, S_EVAL_Q, S_EVAL_C, S_COMMIT} state_t;

  state_t          state_q, state_d;
  logic [XW-1:0]   x_q, x_d, sel_x_q, sel_x_d;
  logic [YW-1:0]   y_q, y_d, sel_y_q, sel_y_d;
  logic [1:0]      dir_q, dir_d, qdir_q, qdir_d;
  logic            cur_valid_q, cur_valid_d, qv_q, qv_d, take_q, take_d;
  logic            moving_q, moving_d, blocked_q, blocked_d, step_done_q, step_done_d;
  logic [DW-1:0]   div_q, div_d;

  logic [1:0]        eval_dir;
  logic signed [XW:0] tx_raw;
  logic signed [YW:0] ty_raw;
  logic [XW-1:0]     tx, cl, cr;
  logic [YW-1:0]     ty, rt, rb;
  logic              wall, pass, tick_attempt;

  function automatic logic [MW-1:0] tidx(input logic [XW-1:0] c, input logic [YW-1:0] r);
    return MW'(r) * MW'(COLS) + MW'(c);
  endfunction

  // One shared target/collision unit; EVAL_Q looks at the queue, EVAL_C at dir.
  always_comb begin
    eval_dir = (state_q == S_EVAL_Q) ? qdir_q : dir_q;
    tx_raw   = $signed({1'b0, x_q});
    ty_raw   = $signed({1'b0, y_q});
    case (eval_dir)
      2'd0:    ty_raw = ty_raw - SPY;
      2'd1:    ty_raw = ty_raw + SPY;
      2'd2:    tx_raw = tx_raw - SPX;
      default: tx_raw = tx_raw + SPX;
    endcase
    if (tx_raw < BX0_S)       tx_raw = (WRAP_X != 0) ? XMAX_S : BX0_S;
    else if (tx_raw > XMAX_S) tx_raw = (WRAP_X != 0) ? BX0_S : XMAX_S;
    if (ty_raw < BY0_S)       ty_raw = BY0_S;
    else if (ty_raw > YMAX_S) ty_raw = YMAX_S;
    tx   = tx_raw[XW-1:0];
    ty   = ty_raw[YW-1:0];
    cl   = tx / TILE_X;
    cr   = (tx + TM1_X) / TILE_X;
    rt   = ty / TILE_Y;
    rb   = (ty + TM1_Y) / TILE_Y;
    wall = tilemap_i[tidx(cl, rt)] | tilemap_i[tidx(cr, rt)] |
           tilemap_i[tidx(cl, rb)] | tilemap_i[tidx(cr, rb)];
    pass = ((tx != x_q) || (ty != y_q)) && !wall;
  end

  always_comb begin
    state_d      = state_q;
    x_d          = x_q;
    y_d          = y_q;
    sel_x_d      = sel_x_q;
    sel_y_d      = sel_y_q;
    dir_d        = dir_q;
    qdir_d       = qdir_q;
    cur_valid_d  = cur_valid_q;
    qv_d         = qv_q;
    take_d       = take_q;
    moving_d     = moving_q;
    blocked_d    = 1'b0;
    step_done_d  = 1'b0;
    div_d        = div_q;
    tick_attempt = 1'b0;

    if (tick_i) begin
      if (div_q == DIV_LAST) begin
        div_d        = '0;
        tick_attempt = 1'b1;
      end else begin
        div_d = div_q + DW'(1);
      end
    end

    // A taken queue still walks through EVAL_C so commit latency is fixed.
    case (state_q)
      S_IDLE: if (tick_attempt) state_d = S_EVAL_Q;
      S_EVAL_Q: begin
        state_d = S_EVAL_C;
        take_d  = 1'b0;
        if (qv_q && pass) begin
          dir_d       = qdir_q;
          cur_valid_d = 1'b1;
          qv_d        = 1'b0;
          sel_x_d     = tx;
          sel_y_d     = ty;
          take_d      = 1'b1;
        end
      end
      S_EVAL_C: begin
        if (take_q) begin
          state_d = S_COMMIT;
        end else if (cur_valid_q && pass) begin
          sel_x_d = tx;
          sel_y_d = ty;
          state_d = S_COMMIT;
        end else begin
          blocked_d = 1'b1;
          moving_d  = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: begin
        x_d         = sel_x_q;
        y_d         = sel_y_q;
        moving_d    = 1'b1;
        step_done_d = 1'b1;
        state_d     = S_IDLE;
      end
    endcase

    // A fresh key press outranks the queue clear from EVAL_Q.
    if (!w_i)      begin qv_d = 1'b1; qdir_d = 2'd0; end
    else if (!s_i) begin qv_d = 1'b1; qdir_d = 2'd1; end
    else if (!a_i) begin qv_d = 1'b1; qdir_d = 2'd2; end
    else if (!d_i) begin qv_d = 1'b1; qdir_d = 2'd3; end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      x_q         <= START_XV;
      y_q         <= START_YV;
      sel_x_q     <= START_XV;
      sel_y_q     <= START_YV;
      dir_q       <= 2'd0;
      qdir_q      <= 2'd0;
      cur_valid_q <= 1'b0;
      qv_q        <= 1'b0;
      take_q      <= 1'b0;
      moving_q    <= 1'b0;
      blocked_q   <= 1'b0;
      step_done_q <= 1'b0;
      div_q       <= '0;
    end else begin
      state_q     <= state_d;
      x_q         <= x_d;
      y_q         <= y_d;
      sel_x_q     <= sel_x_d;
      sel_y_q     <= sel_y_d;
      dir_q       <= dir_d;
      qdir_q      <= qdir_d;
      cur_valid_q <= cur_valid_d;
      qv_q        <= qv_d;
      take_q      <= take_d;
      moving_q    <= moving_d;
      blocked_q   <= blocked_d;
      step_done_q <= step_done_d;
      div_q       <= div_d;
    end
  end

  assign x_o         = x_q;
  assign y_o         = y_q;
  assign dir_o       = dir_q;
  assign moving_o    = moving_q;
  assign blocked_o   = blocked_q;
  assign step_done_o = step_done_q;

endmodule

// File: tb/tb_char_mover_tiled.sv
// Bench for char_mover_tiled: directed scenarios on three parameterisations plus
// a randomized walk checked against a tile-level reference model.
module tb_char_mover_tiled;

  localparam int NT = 768;

  logic           clk   = 1'b0;
  logic           reset = 1'b1;
  logic           tick  = 1'b0;
  logic [3:0]     kn    = 4'hF;  // active-low keys in direction order: w,s,a,d
  logic [NT-1:0]  map   = '0;

  logic [9:0] x_w   [3];
  logic [8:0] y_w   [3];
  logic [1:0] dir_w [3];
  logic       mov_w [3];
  logic       blk_w [3];
  logic       sd_w  [3];

  logic       b2 [3];
  logic       s2 [3];
  logic       s3 [3];
  logic       s4 [3];
  logic [9:0] xa2 [3];

  int checks = 0;
  int errors = 0;

  // model state for the random walk
  int mx, my, mdir, mcv, mqv, mqd, mmov;

  always #5 clk = ~clk;

  char_mover_tiled u_base (
    .clk_i(clk), .reset_i(reset), .tick_i(tick),
    .w_i(kn[0]), .a_i(kn[2]), .s_i(kn[1]), .d_i(kn[3]), .tilemap_i(map),
    .x_o(x_w[0]), .y_o(y_w[0]), .dir_o(dir_w[0]), .moving_o(mov_w[0]),
    .blocked_o(blk_w[0]), .step_done_o(sd_w[0]));

  char_mover_tiled #(.WRAP_X(1)) u_wrap (
    .clk_i(clk), .reset_i(reset), .tick_i(tick),
    .w_i(kn[0]), .a_i(kn[2]), .s_i(kn[1]), .d_i(kn[3]), .tilemap_i(map),
    .x_o(x_w[1]), .y_o(y_w[1]), .dir_o(dir_w[1]), .moving_o(mov_w[1]),
    .blocked_o(blk_w[1]), .step_done_o(sd_w[1]));

  char_mover_tiled #(.STEP_DIV(3)) u_div (
    .clk_i(clk), .reset_i(reset), .tick_i(tick),
    .w_i(kn[0]), .a_i(kn[2]), .s_i(kn[1]), .d_i(kn[3]), .tilemap_i(map),
    .x_o(x_w[2]), .y_o(y_w[2]), .dir_o(dir_w[2]), .moving_o(mov_w[2]),
    .blocked_o(blk_w[2]), .step_done_o(sd_w[2]));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic press(input logic [3:0] mask);
    kn = ~mask;
    @(posedge clk); #1;
    kn = 4'hF;
  endtask

  // Tick sampled at edge T; snapshots taken #1 after edges T+2, T+3, T+4.
  task automatic do_tick();
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      b2[k] = blk_w[k]; s2[k] = sd_w[k]; xa2[k] = x_w[k];
    end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) s3[k] = sd_w[k];
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) s4[k] = sd_w[k];
  endtask

  function automatic bit m_wall(input int px, input int py);
    return map[(py / 20) * 32 + (px / 20)];
  endfunction

  // Target and passability from the movement rules, plain integer arithmetic.
  function automatic bit m_pass(input int px, input int py, input int d,
                                output int nx, output int ny);
    nx = px + ((d == 3) ? 5 : (d == 2) ? -5 : 0);
    ny = py + ((d == 1) ? 5 : (d == 0) ? -5 : 0);
    if (nx < 80)  nx = 80;
    if (nx > 540) nx = 540;
    if (ny < 60)  ny = 60;
    if (ny > 400) ny = 400;
    if (nx == px && ny == py) return 1'b0;
    return !(m_wall(nx, ny) || m_wall(nx + 19, ny) ||
             m_wall(nx, ny + 19) || m_wall(nx + 19, ny + 19));
  endfunction

  initial begin
    int nx, ny;
    bit blk;
    logic [3:0] mask;

    // reset state
    do_reset();
    chk("rst_x", x_w[0], 80);
    chk("rst_y", y_w[0], 60);
    chk("rst_dir", dir_w[0], 0);
    chk("rst_moving", mov_w[0], 0);
    chk("rst_blocked", blk_w[0], 0);
    chk("rst_step_done", sd_w[0], 0);

    // open map, single step right with exact latency
    press(4'b1000);
    do_tick();
    chk("open_x_before", xa2[0], 80);
    chk("open_sd_early", s2[0], 0);
    chk("open_sd", s3[0], 1);
    chk("open_sd_once", s4[0], 0);
    chk("open_x", x_w[0], 85);
    chk("open_dir", dir_w[0], 3);
    chk("open_moving", mov_w[0], 1);

    // wall at col5,row3 blocks the first step
    do_reset();
    map = '0;
    map[3*32+5] = 1'b1;
    press(4'b1000);
    do_tick();
    chk("wall_blocked", b2[0], 1);
    chk("wall_sd", s3[0], 0);
    chk("wall_x", x_w[0], 80);
    chk("wall_moving", mov_w[0], 0);

    // pre-turn: row 4 walled except col6
    do_reset();
    map = '0;
    for (int c = 0; c < 32; c++) if (c != 6) map[4*32+c] = 1'b1;
    press(4'b1000);
    repeat (4) do_tick();
    chk("pre_x100", x_w[0], 100);
    press(4'b0010);
    for (int i = 0; i < 4; i++) begin
      do_tick();
      chk("pre_x", x_w[0], 105 + 5 * i);
      chk("pre_y", y_w[0], 60);
      chk("pre_dir", dir_w[0], 3);
    end
    do_tick();
    chk("turn_x", x_w[0], 120);
    chk("turn_y", y_w[0], 65);
    chk("turn_dir", dir_w[0], 1);

    // left edge: clamp (base) vs tunnel wrap
    do_reset();
    map = '0;
    press(4'b0100);
    do_tick();
    chk("clamp_blocked", b2[0], 1);
    chk("clamp_x", x_w[0], 80);
    chk("wrap_x", x_w[1], 540);
    chk("wrap_sd", s3[1], 1);
    chk("wrap_dir", dir_w[1], 2);

    // STEP_DIV=3 with d held, then reset in the middle of an attempt
    do_reset();
    kn = 4'b0111;
    for (int t = 1; t <= 6; t++) begin
      do_tick();
      chk("div_x", x_w[2], 80 + 5 * (t / 3));
      chk("div_sd", s3[2], (t % 3) == 0);
    end
    do_tick();
    do_tick();
    chk("abort_pre_x", x_w[2], 90);
    tick = 1'b1;
    @(posedge clk); #1;
    tick = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    kn = 4'hF;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
    for (int c = 0; c < 5; c++) begin
      chk("abort_sd", sd_w[2], 0);
      chk("abort_blk", blk_w[2], 0);
      @(posedge clk); #1;
    end
    chk("abort_x", x_w[2], 80);
    chk("abort_y", y_w[2], 60);

    // randomized walk on a random map against the reference model
    do_reset();
    for (int i = 0; i < NT; i++) map[i] = ($urandom_range(0, 9) == 0);
    mx = 80; my = 60; mdir = 0; mcv = 0; mqv = 0; mqd = 0; mmov = 0;
    for (int n = 0; n < 40; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        mask = 4'($urandom_range(1, 15));
        press(mask);
        mqv = 1;
        for (int b = 3; b >= 0; b--) if (mask[b]) mqd = b;
      end
      blk = 1'b0;
      if (mqv != 0 && m_pass(mx, my, mqd, nx, ny)) begin
        mdir = mqd; mcv = 1; mqv = 0; mx = nx; my = ny; mmov = 1;
      end else if (mcv != 0 && m_pass(mx, my, mdir, nx, ny)) begin
        mx = nx; my = ny; mmov = 1;
      end else begin
        mmov = 0; blk = 1'b1;
      end
      do_tick();
      chk("rand_x", x_w[0], mx);
      chk("rand_y", y_w[0], my);
      chk("rand_dir", dir_w[0], mdir);
      chk("rand_moving", mov_w[0], mmov);
      chk("rand_blocked", b2[0], blk);
      chk("rand_sd", s3[0], !blk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
